// File: rtl/tmr_pkg.sv
// tmr_pkg: shared widths, constants and FSM state encoding for the microsecond timer.
package tmr_pkg;
    localparam int TMR_CNT_W = 24;
    localparam int US_HZ     = 1_000_000;
    typedef enum logic [1:0] {TMR_IDLE, TMR_RUN, TMR_EXPIRED} tmr_state_e;
endpackage

// File: rtl/tmr_prescaler.sv
// tmr_prescaler: divides clk by DIV, pulsing tick on the last cycle of each period.
module tmr_prescaler #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt_q;
    assign tick = run && (cnt_q == W'(DIV - 1));
    always_ff @(posedge clk) begin
        if (rst || !run || tick) cnt_q <= '0;
        else                     cnt_q <= cnt_q + W'(1);
    end
endmodule

// File: rtl/tmr.sv
// tmr: microsecond timer; counts a latched number of microseconds and pulses done on expiry,
// either once (one-shot) or every period (auto-reload).
module tmr
    import tmr_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 mode,
    input  logic [TMR_CNT_W-1:0] time_count,
    input  logic                 clear,
    output logic                 done
);
    localparam int C = CLK_FREQ_HZ / US_HZ;
    if (CLK_FREQ_HZ < US_HZ || CLK_FREQ_HZ % US_HZ != 0) begin : g_bad_freq
        $error("tmr: CLK_FREQ_HZ must be a positive multiple of 1 MHz");
    end
    tmr_state_e           state_q;
    logic [TMR_CNT_W-1:0] us_q;
    logic [TMR_CNT_W-1:0] tgt_q;
    logic                 mode_q;
    logic                 done_q;
    logic                 tick;
    tmr_prescaler #(.DIV(C)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .run  (state_q == TMR_RUN && !clear && enable),
        .tick (tick)
    );
    always_ff @(posedge clk) begin
        done_q <= 1'b0;
        if (rst) begin
            state_q <= TMR_IDLE;
            us_q    <= '0;
            tgt_q   <= '0;
            mode_q  <= 1'b0;
        end else if (clear) begin
            state_q <= TMR_IDLE;
            us_q    <= '0;
        end else begin
            case (state_q)
                TMR_IDLE: begin
                    us_q <= '0;
                    if (enable && time_count != '0) begin
                        tgt_q   <= time_count;
                        mode_q  <= mode;
                        state_q <= TMR_RUN;
                    end
                end
                TMR_RUN: begin
                    if (!enable) begin
                        state_q <= TMR_IDLE;
                        us_q    <= '0;
                    end else if (tick) begin
                        // Target is latched non-zero, so target-1 cannot underflow.
                        if (us_q == tgt_q - TMR_CNT_W'(1)) begin
                            done_q <= 1'b1;
                            us_q   <= '0;
                            if (!mode_q) state_q <= TMR_EXPIRED;
                        end else begin
                            us_q <= us_q + TMR_CNT_W'(1);
                        end
                    end
                end
                TMR_EXPIRED: begin
                    us_q <= '0;
                    if (!enable) state_q <= TMR_IDLE;
                end
                default: state_q <= TMR_IDLE;
            endcase
        end
    end
    assign done = done_q;
endmodule
